// File: rtl/sccb_pkg.sv
// sccb_pkg: shared state encoding and constants for the SCCB transaction arbiter.
package sccb_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        BUSY   = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_e;
    localparam logic       ACK_OK         = 1'b0;
    localparam logic [7:0] DEF_SLAVE_ADDR = 8'h42;
endpackage

// File: rtl/sccb_rr_pick.sv
// sccb_rr_pick: two-way round-robin picker; on a tie the port that was not served last wins.
module sccb_rr_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_o,
    output logic gnt_o
);
    assign valid_o = req0_i | req1_i;
    assign gnt_o   = (req0_i && req1_i) ? ~last_i : req1_i;
endmodule

// File: rtl/sccb_txn_arbiter.sv
// sccb_txn_arbiter: shares one SCCB/I2C transaction engine between two requesters,
// with NACK retry, per-attempt timeout and per-port done/err/read-data responses.
module sccb_txn_arbiter
    import sccb_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR    = DEF_SLAVE_ADDR,
    parameter int         MAX_RETRY     = 3,
    parameter int         TIMEOUT_TICKS = 200
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        eng_en,
    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [7:0]  sub0,
    input  logic [7:0]  sub1,
    input  logic [7:0]  wdat0,
    input  logic [7:0]  wdat1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [7:0]  rdat0,
    output logic [7:0]  rdat1,
    output logic        busy,
    output logic        eng_go,
    output logic        eng_wr,
    output logic [23:0] eng_wdata,
    input  logic        eng_end,
    input  logic        eng_ack,
    input  logic [7:0]  eng_rdata
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    state_e        state_q;
    logic [RW-1:0] retry_q;
    logic [TW-1:0] tick_q, tick_d;
    logic          last_q, gnt_q, wr_q, err_q, go_q, busy_q;
    logic          done0_q, done1_q, err0_q, err1_q;
    logic [23:0]   cmd_q;
    logic [7:0]    rd_q, rdat0_q, rdat1_q;
    logic          pick_valid, pick_id, tmo;

    sccb_rr_pick u_pick (
        .req0_i (req0),
        .req1_i (req1),
        .last_i (last_q),
        .valid_o(pick_valid),
        .gnt_o  (pick_id)
    );

    assign tick_d = (tick_q == TW'(TIMEOUT_TICKS)) ? tick_q : tick_q + 1'b1;
    assign tmo    = (tick_d == TW'(TIMEOUT_TICKS));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            retry_q <= '0;
            tick_q  <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            cmd_q   <= '0;
            rd_q    <= '0;
            rdat0_q <= '0;
            rdat1_q <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            if (eng_en) begin
                case (state_q)
                    IDLE: if (pick_valid) begin
                        gnt_q   <= pick_id;
                        wr_q    <= pick_id ? wr1 : wr0;
                        cmd_q   <= {SLAVE_ADDR, pick_id ? sub1 : sub0, pick_id ? wdat1 : wdat0};
                        retry_q <= '0;
                        tick_q  <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        go_q    <= 1'b1;
                        state_q <= LAUNCH;
                    end
                    LAUNCH: begin
                        tick_q <= tick_d;
                        if (tmo) begin
                            err_q   <= 1'b1;
                            go_q    <= 1'b0;
                            state_q <= DONE;
                        end else if (!eng_end) state_q <= BUSY;
                    end
                    BUSY: begin
                        tick_q <= tick_d;
                        // A completed transfer wins over a timeout landing on the same strobe
                        if (eng_end && eng_ack == ACK_OK) begin
                            rd_q    <= eng_rdata;
                            go_q    <= 1'b0;
                            state_q <= DONE;
                        end else if (eng_end && retry_q < RW'(MAX_RETRY)) begin
                            retry_q <= retry_q + 1'b1;
                            go_q    <= 1'b0;
                            state_q <= GAP;
                        end else if (eng_end || tmo) begin
                            err_q   <= 1'b1;
                            go_q    <= 1'b0;
                            state_q <= DONE;
                        end
                    end
                    GAP: begin
                        tick_q  <= '0;
                        go_q    <= 1'b1;
                        state_q <= LAUNCH;
                    end
                    DONE: begin
                        done0_q <= ~gnt_q;
                        done1_q <= gnt_q;
                        err0_q  <= ~gnt_q & err_q;
                        err1_q  <= gnt_q & err_q;
                        if (!wr_q && !err_q && !gnt_q) rdat0_q <= rd_q;
                        if (!wr_q && !err_q && gnt_q) rdat1_q <= rd_q;
                        last_q  <= gnt_q;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdat0     = rdat0_q;
    assign rdat1     = rdat1_q;
    assign busy      = busy_q;
    assign eng_go    = go_q;
    assign eng_wr    = wr_q;
    assign eng_wdata = cmd_q;
endmodule

// File: tb/tb_sccb_txn_arbiter.sv
// tb_sccb_txn_arbiter: table-driven bench with a behavioural SCCB engine and a done scoreboard.
`timescale 1ns/1ps
module tb_sccb_txn_arbiter;
    localparam int TMO = 200;

    logic        iCLK = 1'b0, iRST_N = 1'b0, eng_en = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [7:0]  sub0 = '0, sub1 = '0, wdat0 = '0, wdat1 = '0;
    logic        eng_end = 1'b1, eng_ack = 1'b1;
    logic [7:0]  eng_rdata = '0;
    logic        done0, done1, err0, err1, busy, eng_go, eng_wr;
    logic [7:0]  rdat0, rdat1;
    logic [23:0] eng_wdata;

    sccb_txn_arbiter dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .eng_en(eng_en),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .sub0(sub0), .sub1(sub1), .wdat0(wdat0), .wdat1(wdat1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdat0(rdat0), .rdat1(rdat1), .busy(busy),
        .eng_go(eng_go), .eng_wr(eng_wr), .eng_wdata(eng_wdata),
        .eng_end(eng_end), .eng_ack(eng_ack), .eng_rdata(eng_rdata)
    );

    always #20 iCLK = ~iCLK;

    // Engine model: starts on each eng_go rise, drops END on the next strobe, finishes
    // three strobes later unless hung; NACKs the first nack_cfg attempts of a transaction.
    int          ph = 0, ecnt = 0, go_rises = 0, gohi = 0, gap_cnt = 0, gap_bad = 0;
    logic        go_prev = 1'b0, act = 1'b0;
    logic [23:0] wd_seen = '0;
    int          rise_base = 0, nack_cfg = 0;
    logic        hang = 1'b0;
    logic [7:0]  rd_val = '0;

    always @(negedge iCLK) begin
        ph = (ph + 1) % 4;
        eng_en = (ph == 0);
        if (eng_go && !go_prev) begin
            if (go_rises > rise_base && gap_cnt != 1) gap_bad++;
            go_rises++;
            act = 1'b1;
            ecnt = 0;
            wd_seen = eng_wdata;
        end else if (!eng_go && go_prev) begin
            act = 1'b0;
            eng_end = 1'b1;
            gap_cnt = 0;
        end
        go_prev = eng_go;
        if (eng_en) begin
            if (eng_go) gohi++;
            else gap_cnt++;
            if (act) begin
                ecnt++;
                if (ecnt == 1) eng_end = 1'b0;
                else if (ecnt == 4 && !hang) begin
                    eng_end = 1'b1;
                    eng_ack = ((go_rises - rise_base) <= nack_cfg);
                    eng_rdata = rd_val;
                    act = 1'b0;
                end
            end
        end
    end

    int errs = 0, chks = 0;
    typedef struct { logic port; logic err; logic [7:0] r0; logic [7:0] r1; } exp_t;
    exp_t sbq[$];
    logic [7:0] m_r0 = '0, m_r1 = '0;

    typedef struct {
        logic port; logic wr; logic [7:0] sub; logic [7:0] wdat; logic [7:0] rd;
        int nacks; logic hang; logic exp_err; int exp_rises; logic [23:0] exp_wd;
    } vec_t;
    vec_t tbl[8];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        chks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic sb_poll();
        exp_t e;
        if (done0 || done1) begin
            if (sbq.size() == 0) begin
                chks++;
                errs++;
                $display("FAIL sb_unexpected: got done0=%0b done1=%0b expected none", done0, done1);
            end else begin
                e = sbq.pop_front();
                check("sb_both_done", 32'(done0 & done1), 0);
                check("sb_port", 32'(done1), 32'(e.port));
                check("sb_err", 32'(e.port ? err1 : err0), 32'(e.err));
                check("sb_rdat0", 32'(rdat0), 32'(e.r0));
                check("sb_rdat1", 32'(rdat1), 32'(e.r1));
            end
        end
    endtask

    task automatic push(logic port, logic err);
        sbq.push_back('{port, err, m_r0, m_r1});
    endtask

    task automatic wait_done(logic port, int budget, output logic got, output logic busy_hi);
        got = 1'b0;
        busy_hi = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge iCLK);
            if (busy) busy_hi = 1'b1;
            sb_poll();
            got = port ? done1 : done0;
        end
    endtask

    task automatic run_vec(int idx, vec_t v);
        int   r0, g0, b0;
        logic got, bh;
        rise_base = go_rises;
        nack_cfg = v.nacks;
        hang = v.hang;
        rd_val = v.rd;
        r0 = go_rises;
        g0 = gohi;
        b0 = gap_bad;
        if (!v.wr && !v.exp_err) begin
            if (v.port) m_r1 = v.rd;
            else m_r0 = v.rd;
        end
        push(v.port, v.exp_err);
        @(negedge iCLK);
        if (v.port) begin req1 = 1'b1; wr1 = v.wr; sub1 = v.sub; wdat1 = v.wdat; end
        else begin req0 = 1'b1; wr0 = v.wr; sub0 = v.sub; wdat0 = v.wdat; end
        for (int c = 0; c < 20 && !busy; c++) @(negedge iCLK);
        check($sformatf("v%0d_grant", idx), 32'(busy), 1);
        // Scramble the command after grant; the latched copy must be what reaches the engine
        if (v.port) begin wr1 = ~v.wr; sub1 = ~v.sub; wdat1 = ~v.wdat; end
        else begin wr0 = ~v.wr; sub0 = ~v.sub; wdat0 = ~v.wdat; end
        wait_done(v.port, 2000, got, bh);
        req0 = 1'b0;
        req1 = 1'b0;
        check($sformatf("v%0d_done", idx), 32'(got), 1);
        check($sformatf("v%0d_rises", idx), 32'(go_rises - r0), 32'(v.exp_rises));
        check($sformatf("v%0d_wdata", idx), 32'(wd_seen), 32'(v.exp_wd));
        check($sformatf("v%0d_gap", idx), 32'(gap_bad - b0), 0);
        if (v.hang) check($sformatf("v%0d_tmo_strobes", idx), 32'(gohi - g0), TMO);
        repeat (2) @(negedge iCLK);
        check($sformatf("v%0d_go_idle", idx), 32'(eng_go), 0);
        check($sformatf("v%0d_busy_idle", idx), 32'(busy), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dones;
        logic got, bh;
        tbl[0] = '{1'b0, 1'b1, 8'h12, 8'h80, 8'h00, 0, 1'b0, 1'b0, 1, 24'h421280};
        tbl[1] = '{1'b1, 1'b0, 8'h0A, 8'h00, 8'h77, 0, 1'b0, 1'b0, 1, 24'h420A00};
        tbl[2] = '{1'b0, 1'b1, 8'h34, 8'h56, 8'h00, 2, 1'b0, 1'b0, 3, 24'h423456};
        tbl[3] = '{1'b0, 1'b1, 8'h35, 8'h57, 8'h00, 9, 1'b0, 1'b1, 4, 24'h423557};
        tbl[4] = '{1'b1, 1'b1, 8'h10, 8'hAA, 8'h00, 0, 1'b1, 1'b1, 1, 24'h4210AA};
        tbl[5] = '{1'b0, 1'b0, 8'h0B, 8'h00, 8'h99, 9, 1'b0, 1'b1, 4, 24'h420B00};
        tbl[6] = '{1'b0, 1'b0, 8'h0C, 8'h00, 8'hC3, 1, 1'b0, 1'b0, 2, 24'h420C00};
        tbl[7] = '{1'b1, 1'b0, 8'h1C, 8'h00, 8'h3C, 3, 1'b0, 1'b0, 4, 24'h421C00};

        repeat (3) @(negedge iCLK);
        check("rst_done0", 32'(done0), 0);
        check("rst_done1", 32'(done1), 0);
        check("rst_err", 32'({err0, err1}), 0);
        check("rst_rdat", 32'({rdat0, rdat1}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_go", 32'(eng_go), 0);
        check("rst_wr", 32'(eng_wr), 0);
        check("rst_wdata", 32'(eng_wdata), 0);
        iRST_N = 1'b1;

        // Contention straight after reset: port 0 first, then strict alternation
        rise_base = go_rises;
        nack_cfg = 0;
        hang = 1'b0;
        push(1'b0, 1'b0); push(1'b1, 1'b0); push(1'b0, 1'b0); push(1'b1, 1'b0);
        @(negedge iCLK);
        wr0 = 1'b1; sub0 = 8'h01; wdat0 = 8'h11;
        wr1 = 1'b1; sub1 = 8'h02; wdat1 = 8'h22;
        req0 = 1'b1; req1 = 1'b1;
        dones = 0;
        for (int c = 0; c < 4000 && dones < 4; c++) begin
            @(negedge iCLK);
            sb_poll();
            if (done0 || done1) dones++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("contention_dones", 32'(dones), 4);
        check("contention_left", 32'(sbq.size()), 0);
        repeat (8) @(negedge iCLK);

        for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

        // Reset while a hung transfer is in BUSY, then a fresh grant to the still-requesting port
        rise_base = go_rises;
        nack_cfg = 0;
        hang = 1'b1;
        @(negedge iCLK);
        req0 = 1'b1; wr0 = 1'b1; sub0 = 8'h44; wdat0 = 8'h55;
        for (int c = 0; c < 40 && !eng_go; c++) begin
            @(negedge iCLK);
            sb_poll();
        end
        repeat (8) begin
            @(negedge iCLK);
            sb_poll();
        end
        check("pre_rst_go", 32'(eng_go), 1);
        iRST_N = 1'b0;
        #1;
        check("midrst_go", 32'(eng_go), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'({done0, done1}), 0);
        check("midrst_rdat1", 32'(rdat1), 0);
        m_r0 = '0;
        m_r1 = '0;
        hang = 1'b0;
        repeat (3) @(negedge iCLK);
        rise_base = go_rises;
        push(1'b0, 1'b0);
        iRST_N = 1'b1;
        wait_done(1'b0, 2000, got, bh);
        req0 = 1'b0;
        check("postrst_done", 32'(got), 1);
        check("postrst_busy_seen", 32'(bh), 1);
        check("postrst_wdata", 32'(wd_seen), 32'h424455);
        repeat (12) begin
            @(negedge iCLK);
            sb_poll();
        end
        check("final_busy", 32'(busy), 0);
        check("final_sb_empty", 32'(sbq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule

// File: doc/sccb_txn_arbiter.md
Name: sccb_txn_arbiter

Overview:
- Shares the single I2C/SCCB transaction engine (I2C_Controller instance) between two requesters.
  - Requester 0: the power-up LUT configuration sequencer.
  - Requester 1: the runtime camera tuner (exposure/gain writes, ID reads).
- Latches one command per grant, drives the engine's GO/WR/WDATA and retries on NACK.
- Enforces a timeout and returns a per-requester done/error/read-data response.
- Sits between the requesters and the engine; the engine's pins go to the OV7725.

Parameters:
- SLAVE_ADDR, 8'h42, device write address placed in WDATA[23:16].
- MAX_RETRY, 3, extra attempts after a NACK before reporting an error.
- TIMEOUT_TICKS, 200, eng_en strobes allowed per attempt before abort.

Ports:
- iCLK in 1: system clock, 25 MHz.
- iRST_N in 1: asynchronous active-low reset.
- eng_en in 1: one-iCLK strobe on each falling edge of the I2C control clock. All FSM decisions are taken only on cycles with eng_en=1.
- req0, req1 in 1: request level; held until that port's done pulse.
- wr0, wr1 in 1: 1 = write, 0 = read.
- sub0, sub1 in 8: register sub-address.
- wdat0, wdat1 in 8: write data. Don't-care for reads.
- done0, done1 out 1: one-iCLK completion pulse.
- err0, err1 out 1: valid with done; 1 = NACK exhausted or timeout.
- rdat0, rdat1 out 8: read data. Updated only on a successful read's done; held otherwise.
- busy out 1: high from grant until done.
- eng_go out 1: engine GO level.
- eng_wr out 1: engine WR.
- eng_wdata out 24: {SLAVE_ADDR, sub, wdat} of the latched command.
- eng_end in 1: engine END. 0 while transferring, 1 when idle/finished.
- eng_ack in 1: engine ACK. 0 = acknowledged, 1 = NACK. Valid when eng_end=1 after a transfer.
- eng_rdata in 8: engine read byte.

Behaviour:
- Reset: all outputs 0, state IDLE, retry_cnt=0, tick_cnt=0, last_grant=1 (so port 0 wins the first tie). Reset mid-transfer drops eng_go immediately. Any pending request is re-arbitrated after reset.
- States: IDLE, LAUNCH, BUSY, GAP, DONE. Transitions happen only on eng_en cycles.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port not equal to last_grant (round-robin).
  - On grant: latch wr/sub/wdat, set gnt_id, clear retry_cnt and tick_cnt, go to LAUNCH.
  - busy rises in the same cycle.
- LAUNCH: eng_go=1, eng_wr=latched wr. When eng_end=0 (transfer started), go to BUSY.
- BUSY: eng_go stays 1. When eng_end=1:
  - eng_ack=0: capture eng_rdata if read, go to DONE with err=0.
  - eng_ack=1 and retry_cnt<MAX_RETRY: retry_cnt+1, go to GAP.
  - Otherwise: go to DONE with err=1.
- GAP: eng_go=0 for exactly one strobe, clear tick_cnt, then LAUNCH (same command).
- Timeout: tick_cnt increments each strobe in LAUNCH/BUSY. At TIMEOUT_TICKS, go to DONE with err=1 and drop eng_go. Timeout is not retried.
- DONE (one strobe cycle):
  - eng_go=0.
  - Pulse done<gnt_id> with err<gnt_id>.
  - Write rdat<gnt_id> only on a successful read.
  - last_grant=gnt_id; busy falls; next state IDLE.
- Next grant: a requester still holding req after its own done may not be re-granted in the same strobe. The earliest re-arbitration is the next strobe in IDLE.
- eng_go is 0 in IDLE/GAP/DONE and 1 in LAUNCH/BUSY.
- eng_wr/eng_wdata are stable from grant to DONE.
- Mid-transaction changes:
  - Command fields changing while granted are ignored (latched copy is used).
  - req dropped while granted: the transaction still completes and done still pulses.
- Width rules: retry_cnt uses clog2(MAX_RETRY+1) bits; tick_cnt uses clog2(TIMEOUT_TICKS+1) bits. Neither wraps; both saturate at their limit.

Decomposition:
- Shared package/header sccb_pkg:
  - state encodings (IDLE=0, LAUNCH=1, BUSY=2, GAP=3, DONE=4);
  - ACK_OK=1'b0;
  - default SLAVE_ADDR 8'h42.
- One sub-module, sccb_rr_pick: combinational two-way round-robin picker over req0/req1/last_grant, giving valid and gnt_id.

Test Plan:
- Single write: req0, wr0=1, sub0=8'h12, wdat0=8'h80, engine ACKs → eng_wdata=24'h421280; one done0 with err0=0; busy 0→1→0; eng_go low after.
- Read: req1, wr1=0, sub1=8'h0A, engine returns 8'h77 with ACK → done1, err1=0, rdat1=8'h77; rdat0 unchanged.
- Contention: req0 and req1 asserted in the same cycle after reset → port 0 served first, port 1 next. With both held continuously, grants alternate 0,1,0,1.
- NACK: engine NACKs twice then ACKs → exactly 3 eng_go rising edges, each separated by one GAP strobe low; done0 err0=0. Always NACK → 4 attempts (MAX_RETRY=3), then err0=1.
- Timeout: eng_end held 0 forever → at tick 200, eng_go drops, done pulses with err=1, no retry.
- Reset mid-BUSY: assert iRST_N=0 → eng_go, busy, done0/1 immediately 0. After release with req0 still high → fresh grant to port 0.
